camo_cfg_loader: RTL and testbench
==================================

// Module: camo_cfg_loader
// PURPOSE
// - Serial loader/sequencer for the 2-bit select pairs (D_{2i}, D_{2i+1}) that drive the obfuscated-gate cells.
// - Each cell's function is set by its pair: buffer, invert, const1 or const0.
// - Codes stream in one per cycle and are collected in a shadow register.
// - Codes are validated, then committed atomically to the live select bus; a settle window follows before done is reported.
// PARAMETERS
// - NUM_CELLS   5   obfuscated cells controlled; live bus width is 2*NUM_CELLS
// - SETTLE_CYC  4   cycles (>=1) the live bus is held before cfg_done asserts
// - RST_CODE    2'b00   per-cell code on reset; all cells are buffers (transparent)
// PORTS
// - Timing: one clock; reset is asynchronous and active-low
// - clk        in   1            system clock, rising edge
// - rst_n      in   1            async active-low reset
// - cfg_valid  in   1            cfg_data is valid this cycle
// - cfg_ready  out  1            loader accepts a code; transfer = cfg_valid & cfg_ready
// - cfg_data   in   2            {D_2i, D_2i+1} for the next cell; cell 0 first
// - cfg_last   in   1            marks the final code of a frame
// - commit     in   1            one-cycle pulse: copy shadow to live bus
// - abort      in   1            drop the frame in progress
// - d_out      out  2*NUM_CELLS  live selects; d_out[2i]=D_2i, d_out[2i+1]=D_2i+1
// - busy       out  1            high in any state other than IDLE
// - cfg_done   out  1            one-cycle pulse at the end of the settle window
// - cfg_err    out  1            sticky frame-length error; cleared by the next accepted first code
// BEHAVIOUR
// - Cell encoding (D_2i,D_2i+1):
//   - 00 buffer
//   - 01 invert
//   - 10 const1
//   - 11 const0
// - Reset values:
//   - state = IDLE; every cell of d_out = RST_CODE
//   - shadow = RST_CODE; idx = 0
//   - cfg_ready = 1; busy = 0; cfg_done = 0; cfg_err = 0
// - FSM states: IDLE, LOAD, ARMED, SETTLE
// - IDLE:
//   - cfg_ready = 1
//   - A transfer writes shadow[idx=0], sets idx = 1, clears cfg_err, goes to LOAD
//   - If that first transfer also has cfg_last: NUM_CELLS==1 goes to ARMED; otherwise it is an error
// - LOAD:
//   - cfg_ready = 1; each transfer writes shadow[idx] and increments idx
//   - cfg_last on code NUM_CELLS-1: go to ARMED, idx = 0
//   - cfg_last on an earlier code: cfg_err = 1, go to IDLE, shadow discarded
//   - Code NUM_CELLS-1 without cfg_last: same error handling
//   - d_out is never disturbed during LOAD
// - ARMED:
//   - cfg_ready = 0
//   - commit: d_out <= shadow on that edge, load counter = SETTLE_CYC-1, go to SETTLE
//   - commit arriving earlier (IDLE or LOAD) is ignored
// - SETTLE:
//   - cfg_ready = 0; the counter decrements
//   - At zero: cfg_done pulses for one cycle, return to IDLE
//   - Total: cfg_done is high exactly SETTLE_CYC cycles after the commit edge
// - abort:
//   - In LOAD or ARMED: go to IDLE, idx = 0, d_out unchanged, no error flagged
//   - In SETTLE: ignored, so the committed bus always completes its settle window
//   - abort and commit in the same cycle in ARMED: abort wins
// - Same-cycle events:
//   - cfg_valid with abort in LOAD: the code is dropped
//   - cfg_valid while cfg_ready = 0: no transfer; the source must hold its data
// - Async reset at any point (including SETTLE): immediately returns d_out to RST_CODE and every state to its reset value
// - d_out changes only on a commit edge or on reset, never glitches mid-frame; driven from flops
// TESTING
// - Reset:
//   - Stimulus: assert rst_n=0 mid-SETTLE
//   - Expect d_out = all zeros (10'h000), busy = 0, cfg_ready = 1, no cfg_done
// - Full load (NUM_CELLS=5):
//   - Stimulus: codes 00,01,10,11,01 (last on the 5th), then commit
//   - Expect d_out = 10'b10_11_01_10_00 on the commit edge; cfg_done 4 cycles later
// - Short frame:
//   - Stimulus: cfg_last on the 3rd code
//   - Expect cfg_err = 1, return to IDLE, d_out unchanged
//   - The next valid frame clears cfg_err on its first accepted code
// - Backpressure:
//   - Stimulus: hold cfg_valid through ARMED and SETTLE
//   - Expect cfg_ready = 0 and no writes to shadow; the held code is accepted in IDLE as cell 0
// - Abort:
//   - In LOAD after 2 codes: expect IDLE, d_out unchanged
//   - abort with commit in ARMED: expect no commit
//   - abort in SETTLE: ignored, cfg_done still fires
// - Early commit:
//   - Stimulus: commit pulse in LOAD
//   - Expect it is ignored; the frame completes and waits in ARMED for a later commit

Source files
------------

// File: rtl/camo_cfg_loader.sv
// Serial loader for the obfuscated-gate select pairs. Codes are collected in a
// shadow register, checked for frame length, then committed to the live bus in
// one edge. A settle window follows before cfg_done pulses.
module camo_cfg_loader #(
  parameter int unsigned NUM_CELLS  = 5,
  parameter int unsigned SETTLE_CYC = 4,
  parameter logic [1:0]  RST_CODE   = 2'b00
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   cfg_valid,
  output logic                   cfg_ready,
  input  logic [1:0]             cfg_data,
  input  logic                   cfg_last,
  input  logic                   commit,
  input  logic                   abort,
  output logic [2*NUM_CELLS-1:0] d_out,
  output logic                   busy,
  output logic                   cfg_done,
  output logic                   cfg_err
);

  localparam int unsigned IdxW = (NUM_CELLS > 1) ? $clog2(NUM_CELLS) : 1;
  localparam int unsigned CntW = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
  localparam int unsigned BusW = 2 * NUM_CELLS;

  localparam logic [IdxW-1:0] LastIdx    = IdxW'(NUM_CELLS - 1);
  localparam logic [CntW-1:0] SettleLoad = CntW'(SETTLE_CYC - 1);
  // cfg_data is {D_2i, D_2i+1} but the bus puts D_2i at the lower bit, so each
  // pair lands bit-swapped.
  localparam logic [BusW-1:0] RstBus     = {NUM_CELLS{RST_CODE[0], RST_CODE[1]}};

  typedef enum logic [1:0] {StIdle, StLoad, StArmed, StSettle} state_e;

  state_e          state_q, state_d;
  logic [IdxW-1:0] idx_q, idx_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [BusW-1:0] shadow_q, shadow_d;
  logic [BusW-1:0] dout_q, dout_d;
  logic            done_q, done_d;
  logic            err_q, err_d;

  // Codes are only accepted while collecting a frame.
  assign cfg_ready = (state_q == StIdle) || (state_q == StLoad);
  assign busy      = (state_q != StIdle);
  assign d_out     = dout_q;
  assign cfg_done  = done_q;
  assign cfg_err   = err_q;

  // Next-state: frame collection, length check, commit and settle countdown.
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    cnt_d    = cnt_q;
    shadow_d = shadow_q;
    dout_d   = dout_q;
    done_d   = 1'b0;
    err_d    = err_q;
    unique case (state_q)
      StIdle, StLoad: begin
        if ((state_q == StLoad) && abort) begin
          // Abort drops any code offered in the same cycle.
          state_d = StIdle;
          idx_d   = '0;
        end else if (cfg_valid) begin
          if (state_q == StIdle) begin
            err_d = 1'b0;
          end
          for (int i = 0; i < int'(NUM_CELLS); i++) begin
            if (idx_q == IdxW'(i)) begin
              shadow_d[2*i]   = cfg_data[1];
              shadow_d[2*i+1] = cfg_data[0];
            end
          end
          if (idx_q == LastIdx) begin
            state_d = cfg_last ? StArmed : StIdle;
            err_d   = cfg_last ? err_d : 1'b1;
            idx_d   = '0;
          end else if (cfg_last) begin
            state_d = StIdle;
            err_d   = 1'b1;
            idx_d   = '0;
          end else begin
            state_d = StLoad;
            idx_d   = idx_q + IdxW'(1);
          end
        end
      end
      StArmed: begin
        if (abort) begin
          state_d = StIdle;
          idx_d   = '0;
        end else if (commit) begin
          dout_d  = shadow_q;
          cnt_d   = SettleLoad;
          state_d = StSettle;
        end
      end
      StSettle: begin
        // abort is deliberately ignored so the new bus always settles fully.
        if (cnt_q == '0) begin
          done_d  = 1'b1;
          state_d = StIdle;
        end else begin
          cnt_d = cnt_q - CntW'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State and datapath registers; reset forces the live bus back to RST_CODE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      idx_q    <= '0;
      cnt_q    <= '0;
      shadow_q <= RstBus;
      dout_q   <= RstBus;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      cnt_q    <= cnt_d;
      shadow_q <= shadow_d;
      dout_q   <= dout_d;
      done_q   <= done_d;
      err_q    <= err_d;
    end
  end

endmodule

// File: tb/tb_camo_cfg_loader.sv
// Bench for camo_cfg_loader: directed scenarios plus random traffic, all
// checked against a frame-level model built from queues and counters.
module tb_camo_cfg_loader;

  localparam int unsigned NumCells  = 5;
  localparam int unsigned SettleCyc = 4;
  localparam int unsigned BusW      = 2 * NumCells;

  logic            clk = 1'b0;
  logic            rst_n = 1'b1;
  logic            cfg_valid = 1'b0;
  logic [1:0]      cfg_data = 2'b00;
  logic            cfg_last = 1'b0;
  logic            commit = 1'b0;
  logic            abort = 1'b0;
  logic            cfg_ready;
  logic [BusW-1:0] d_out;
  logic            busy;
  logic            cfg_done;
  logic            cfg_err;

  camo_cfg_loader #(
    .NUM_CELLS (NumCells),
    .SETTLE_CYC(SettleCyc),
    .RST_CODE  (2'b00)
  ) u_dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .cfg_valid(cfg_valid),
    .cfg_ready(cfg_ready),
    .cfg_data (cfg_data),
    .cfg_last (cfg_last),
    .commit   (commit),
    .abort    (abort),
    .d_out    (d_out),
    .busy     (busy),
    .cfg_done (cfg_done),
    .cfg_err  (cfg_err)
  );

  always #5 clk = ~clk;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  // Reference model: live cell codes, the frame being gathered, a complete
  // frame waiting for commit, and the remaining settle cycles.
  logic [1:0] m_live[NumCells];
  logic [1:0] m_frame[$];
  logic [1:0] m_armed[$];
  bit         m_is_armed;
  int         m_left;
  bit         m_err;
  bit         m_done;

  function automatic logic [BusW-1:0] pack_bus();
    logic [BusW-1:0] v;
    for (int i = 0; i < int'(NumCells); i++) begin
      v[2*i]   = m_live[i][1];
      v[2*i+1] = m_live[i][0];
    end
    return v;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < int'(NumCells); i++) m_live[i] = 2'b00;
    m_frame.delete();
    m_armed.delete();
    m_is_armed = 1'b0;
    m_left     = 0;
    m_err      = 1'b0;
    m_done     = 1'b0;
  endtask

  task automatic model_next(input bit v, input logic [1:0] d, input bit l, input bit c,
                            input bit a);
    m_done = 1'b0;
    if (m_left > 0) begin
      if (m_left == 1) m_done = 1'b1;
      m_left--;
    end else if (m_is_armed) begin
      if (a) begin
        m_is_armed = 1'b0;
      end else if (c) begin
        for (int i = 0; i < int'(NumCells); i++) m_live[i] = m_armed[i];
        m_is_armed = 1'b0;
        m_left     = SettleCyc;
      end
    end else if ((m_frame.size() > 0) && a) begin
      m_frame.delete();
    end else if (v) begin
      if (m_frame.size() == 0) m_err = 1'b0;
      m_frame.push_back(d);
      if ((m_frame.size() == int'(NumCells)) && l) begin
        m_armed    = m_frame;
        m_is_armed = 1'b1;
        m_frame.delete();
      end else if ((m_frame.size() == int'(NumCells)) || l) begin
        m_err = 1'b1;
        m_frame.delete();
      end
    end
  endtask

  task automatic check_outputs();
    check("d_out", 32'(d_out), 32'(pack_bus()));
    check("cfg_ready", 32'(cfg_ready), 32'((m_left == 0) && !m_is_armed));
    check("busy", 32'(busy), 32'((m_frame.size() > 0) || m_is_armed || (m_left > 0)));
    check("cfg_done", 32'(cfg_done), 32'(m_done));
    check("cfg_err", 32'(cfg_err), 32'(m_err));
  endtask

  // Drive one cycle of inputs on the falling edge, check just after the rise.
  task automatic step(input bit v, input logic [1:0] d, input bit l, input bit c, input bit a);
    @(negedge clk);
    cfg_valid = v;
    cfg_data  = d;
    cfg_last  = l;
    commit    = c;
    abort     = a;
    model_next(v, d, l, c, a);
    @(posedge clk);
    #1;
    check_outputs();
  endtask

  task automatic idle();
    step(1'b0, 2'b00, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic do_reset(input string tag);
    @(negedge clk);
    #2;
    cfg_valid = 1'b0;
    cfg_last  = 1'b0;
    commit    = 1'b0;
    abort     = 1'b0;
    rst_n     = 1'b0;
    #1;
    check({tag, "_dout"}, 32'(d_out), 32'h000);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_ready"}, 32'(cfg_ready), 32'd1);
    check({tag, "_done"}, 32'(cfg_done), 32'd0);
    check({tag, "_err"}, 32'(cfg_err), 32'd0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    int done_at;
    bit v, l, c, a;
    logic [1:0] d;

    model_reset();
    #1;
    do_reset("por");

    // Full load 00,01,10,11,01 then commit.
    step(1'b1, 2'b00, 1'b0, 1'b0, 1'b0);
    step(1'b1, 2'b01, 1'b0, 1'b0, 1'b0);
    step(1'b1, 2'b10, 1'b0, 1'b0, 1'b0);
    step(1'b1, 2'b11, 1'b0, 1'b0, 1'b0);
    step(1'b1, 2'b01, 1'b1, 1'b0, 1'b0);
    check("armed_busy", 32'(busy), 32'd1);
    step(1'b0, 2'b00, 1'b0, 1'b1, 1'b0);
    check("full_load_dout", 32'(d_out), 32'(10'b10_11_01_10_00));
    done_at = 0;
    for (int k = 1; k <= 8; k++) begin
      idle();
      if (cfg_done === 1'b1) begin
        done_at = k;
        break;
      end
    end
    check("settle_len", 32'(done_at), 32'(SettleCyc));

    // Short frame, then the next first code clears the error.
    step(1'b1, 2'b01, 1'b0, 1'b0, 1'b0);
    step(1'b1, 2'b10, 1'b0, 1'b0, 1'b0);
    step(1'b1, 2'b11, 1'b1, 1'b0, 1'b0);
    check("short_err", 32'(cfg_err), 32'd1);
    check("short_idle", 32'(busy), 32'd0);
    check("short_dout", 32'(d_out), 32'(10'b10_11_01_10_00));
    step(1'b1, 2'b00, 1'b0, 1'b0, 1'b0);
    check("err_cleared", 32'(cfg_err), 32'd0);

    // Abort in LOAD after two codes; the code offered with it is dropped.
    step(1'b1, 2'b01, 1'b0, 1'b0, 1'b0);
    step(1'b1, 2'b11, 1'b0, 1'b0, 1'b1);
    check("abort_load_idle", 32'(busy), 32'd0);

    // Early commit in LOAD is ignored; abort beats commit in ARMED.
    step(1'b1, 2'b11, 1'b0, 1'b0, 1'b0);
    step(1'b1, 2'b11, 1'b0, 1'b1, 1'b0);
    step(1'b1, 2'b11, 1'b0, 1'b1, 1'b0);
    step(1'b1, 2'b11, 1'b0, 1'b0, 1'b0);
    step(1'b1, 2'b11, 1'b1, 1'b0, 1'b0);
    idle();
    idle();
    check("early_commit_armed", 32'(cfg_ready), 32'd0);
    step(1'b0, 2'b00, 1'b0, 1'b1, 1'b1);
    check("abort_commit_dout", 32'(d_out), 32'(10'b10_11_01_10_00));
    check("abort_commit_idle", 32'(busy), 32'd0);

    // Backpressure: hold a code through ARMED and SETTLE; abort in SETTLE ignored.
    for (int i = 0; i < int'(NumCells); i++) begin
      step(1'b1, 2'b11, (i == int'(NumCells) - 1), 1'b0, 1'b0);
    end
    step(1'b1, 2'b01, 1'b0, 1'b0, 1'b0);
    step(1'b1, 2'b01, 1'b0, 1'b1, 1'b0);
    check("bp_all_const0", 32'(d_out), 32'h3ff);
    step(1'b1, 2'b01, 1'b0, 1'b0, 1'b1);
    for (int k = 0; k < 8 && busy === 1'b1; k++) step(1'b1, 2'b01, 1'b0, 1'b0, 1'b0);
    step(1'b1, 2'b01, 1'b0, 1'b0, 1'b0);
    check("bp_held_accepted", 32'(busy), 32'd1);
    step(1'b1, 2'b00, 1'b0, 1'b0, 1'b0);
    step(1'b1, 2'b00, 1'b0, 1'b0, 1'b0);
    step(1'b1, 2'b00, 1'b0, 1'b0, 1'b0);
    step(1'b1, 2'b10, 1'b1, 1'b0, 1'b0);
    step(1'b0, 2'b00, 1'b0, 1'b1, 1'b0);
    check("bp_dout", 32'(d_out), 32'(10'b01_00_00_00_10));

    // Async reset in the middle of the settle window.
    idle();
    do_reset("mid_settle");
    for (int k = 0; k < 6; k++) idle();

    // Random traffic.
    for (int it = 0; it < 3000; it++) begin
      if (it == 1500) do_reset("rand");
      v = ($urandom_range(0, 9) < 7);
      d = 2'($urandom);
      if (m_frame.size() + 1 == int'(NumCells)) l = ($urandom_range(0, 9) != 0);
      else l = ($urandom_range(0, 29) == 0);
      c = ($urandom_range(0, 3) == 0);
      a = ($urandom_range(0, 29) == 0);
      step(v, d, l, c, a);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
